// File: rtl/sip_pkg.sv
// Shared SipHash round definitions: rotation amounts, lane-state struct,
// 64-bit rotate helpers and the inverse-round engine FSM encoding.
package sip_pkg;

   localparam int SIP_ROT_V1_A = 13;
   localparam int SIP_ROT_V3_A = 16;
   localparam int SIP_ROT_V1_B = 17;
   localparam int SIP_ROT_V3_B = 21;
   localparam int SIP_ROT_HALF = 32;

   typedef struct packed {
      logic [63:0] v0;
      logic [63:0] v1;
      logic [63:0] v2;
      logic [63:0] v3;
   } sip_state_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } sip_inv_state_t;

   // Rotates are done through a doubled word so a zero amount stays well defined.
   function automatic logic [63:0] rotl64(input logic [63:0] x, input int unsigned n);
      logic [127:0] t;
      t = {x, x} << (n % 64);
      return t[127:64];
   endfunction

   function automatic logic [63:0] rotr64(input logic [63:0] x, input int unsigned n);
      logic [127:0] t;
      t = {x, x} >> (n % 64);
      return t[63:0];
   endfunction

endpackage

// File: rtl/sip_inv_half_round.sv
// One inverse SipRound half-round, purely combinational.
// SWAP=0 gives inverse-A (lane 0 carries the rotated half, lane 2 is the
// subtract target of the v3 path); SWAP=1 exchanges lanes 0 and 2 for inverse-B.
module sip_inv_half_round
   import sip_pkg::*;
#(
   parameter int ROT_V1 = SIP_ROT_V1_A,
   parameter int ROT_V3 = SIP_ROT_V3_A,
   parameter bit SWAP   = 1'b0
) (
   input  sip_state_t x,
   output sip_state_t y
);

   logic [63:0] p, r, s, n1, np, n3, nr;

   // Undo the add/rotate/xor chains of the forward half-round, mod 2^64.
   always_comb begin
      p  = SWAP ? x.v2 : x.v0;
      r  = SWAP ? x.v0 : x.v2;
      s  = rotr64(p, SIP_ROT_HALF);
      n1 = rotr64(x.v1 ^ s, ROT_V1);
      np = s - n1;
      n3 = rotr64(x.v3 ^ r, ROT_V3);
      nr = r - n3;
      y.v0 = SWAP ? nr : np;
      y.v1 = n1;
      y.v2 = SWAP ? np : nr;
      y.v3 = n3;
   end

endmodule

// File: rtl/sip_inv_rounds.sv
// Iterative inverse-SipRound engine: one inverse half-round per clock,
// valid/ready on input and output.
// Optional feature macro: SIP_INV_BLK_CNT_EN adds a 32-bit completed-block counter.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | accepting a new state + round count
// RUN     | applying half-rounds; cnt even -> inverse-B, odd -> inverse-A
// DONE    | result presented, held until out_ready
module sip_inv_rounds
   import sip_pkg::*;
#(
   parameter int MAX_ROUNDS = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  in_rounds,
   input  logic [63:0] v0_in,
   input  logic [63:0] v1_in,
   input  logic [63:0] v2_in,
   input  logic [63:0] v3_in,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] v0_out,
   output logic [63:0] v1_out,
   output logic [63:0] v2_out,
   output logic [63:0] v3_out
`ifdef SIP_INV_BLK_CNT_EN
   ,
   output logic [31:0] blk_cnt
`endif
);

   localparam int CNT_W = $clog2(2 * MAX_ROUNDS + 1);
   localparam logic [3:0] MAX_R4 = (MAX_ROUNDS > 15) ? 4'd15 : 4'(MAX_ROUNDS);

   sip_inv_state_t   state;
   sip_state_t       st;
   sip_state_t       half_a;
   sip_state_t       half_b;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] load_cnt;
   logic [3:0]       r_clamped;
   logic             in_ready_q;

   assign r_clamped = (in_rounds > MAX_R4) ? MAX_R4 : in_rounds;
   assign load_cnt  = CNT_W'({r_clamped, 1'b0});

   // in_ready is held low for as long as reset is asserted.
   assign in_ready = in_ready_q & ~rst;

   assign v0_out = st.v0;
   assign v1_out = st.v1;
   assign v2_out = st.v2;
   assign v3_out = st.v3;

   sip_inv_half_round #(
      .ROT_V1 (SIP_ROT_V1_A),
      .ROT_V3 (SIP_ROT_V3_A),
      .SWAP   (1'b0)
   ) u_half_a (
      .x (st),
      .y (half_a)
   );

   sip_inv_half_round #(
      .ROT_V1 (SIP_ROT_V1_B),
      .ROT_V3 (SIP_ROT_V3_B),
      .SWAP   (1'b1)
   ) u_half_b (
      .x (st),
      .y (half_b)
   );

   // Sequencing FSM: load, iterate half-rounds, hold the result for the handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         in_ready_q <= 1'b1;
         out_valid  <= 1'b0;
         cnt        <= '0;
         st         <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  st         <= '{v0: v0_in, v1: v1_in, v2: v2_in, v3: v3_in};
                  cnt        <= load_cnt;
                  in_ready_q <= 1'b0;
                  if (load_cnt == '0) begin
                     state     <= ST_DONE;
                     out_valid <= 1'b1;
                  end else begin
                     state <= ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               st  <= cnt[0] ? half_a : half_b;
               cnt <= cnt - 1'b1;
               if (cnt == CNT_W'(1)) begin
                  state     <= ST_DONE;
                  out_valid <= 1'b1;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  state      <= ST_IDLE;
                  out_valid  <= 1'b0;
                  in_ready_q <= 1'b1;
               end
            end
            default: begin
               state      <= ST_IDLE;
               in_ready_q <= 1'b1;
               out_valid  <= 1'b0;
            end
         endcase
      end
   end

`ifdef SIP_INV_BLK_CNT_EN
   // Count completed output handshakes; wraps naturally at 32 bits.
   always_ff @(posedge clk) begin
      if (rst) begin
         blk_cnt <= '0;
      end else if (out_valid && out_ready) begin
         blk_cnt <= blk_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_sip_inv_rounds.sv
// Scoreboard bench for sip_inv_rounds: expected pre-round states come from a
// forward SipRound model and are queued when a block is driven.
module tb_sip_inv_rounds;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_rounds;
   logic [63:0] v0_in, v1_in, v2_in, v3_in;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] v0_out, v1_out, v2_out, v3_out;
`ifdef SIP_INV_BLK_CNT_EN
   logic [31:0] blk_cnt;
`endif

   int n_checks = 0;
   int n_errors = 0;
   logic [255:0] exp_q[$];

   always #5 clk = ~clk;

   sip_inv_rounds #(.MAX_ROUNDS(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_rounds (in_rounds),
      .v0_in     (v0_in),
      .v1_in     (v1_in),
      .v2_in     (v2_in),
      .v3_in     (v3_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .v0_out    (v0_out),
      .v1_out    (v1_out),
      .v2_out    (v2_out),
      .v3_out    (v3_out)
`ifdef SIP_INV_BLK_CNT_EN
      ,
      .blk_cnt   (blk_cnt)
`endif
   );

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s got %h exp %h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] rl(input logic [63:0] x, input int n);
      return (x << n) | (x >> (64 - n));
   endfunction

   // Forward SipRound reference.
   function automatic logic [255:0] fwd_round(input logic [255:0] s);
      logic [63:0] v0, v1, v2, v3;
      {v0, v1, v2, v3} = s;
      v0 = v0 + v1; v1 = rl(v1, 13); v1 = v1 ^ v0; v0 = rl(v0, 32);
      v2 = v2 + v3; v3 = rl(v3, 16); v3 = v3 ^ v2;
      v0 = v0 + v3; v3 = rl(v3, 21); v3 = v3 ^ v0;
      v2 = v2 + v1; v1 = rl(v1, 17); v1 = v1 ^ v2; v2 = rl(v2, 32);
      return {v0, v1, v2, v3};
   endfunction

   function automatic logic [255:0] fwd_n(input logic [255:0] s, input int n);
      logic [255:0] t;
      t = s;
      for (int i = 0; i < n; i++) t = fwd_round(t);
      return t;
   endfunction

   function automatic logic [255:0] rnd_state();
      return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
   endfunction

   // Called at a negedge; returns at a negedge after the output handshake.
   task automatic run_block(input logic [255:0] din, input logic [3:0] r,
                            input logic [255:0] dexp, input string tag);
      int k;
      int lat;
      int exp_lat;
      exp_lat = 2 * ((r > 4'd8) ? 8 : int'(r));
      exp_q.push_back(dexp);
      {v0_in, v1_in, v2_in, v3_in} = din;
      in_rounds = r;
      in_valid  = 1'b1;
      k = 0;
      while (!in_ready && k < 50) begin
         @(negedge clk);
         k++;
      end
      chk({tag, "_accept"}, 256'(in_ready), 256'(1));
      @(negedge clk);
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 60) begin
         @(negedge clk);
         lat++;
      end
      chk({tag, "_lat"}, 256'(lat), 256'(exp_lat));
      chk(tag, {v0_out, v1_out, v2_out, v3_out}, exp_q.pop_front());
      @(negedge clk);
      chk({tag, "_rdy_after"}, 256'(in_ready), 256'(1));
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [255:0] pre, post, hold;
      int r, k;

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_rounds = 4'd0;
      {v0_in, v1_in, v2_in, v3_in} = '0;
      repeat (3) @(negedge clk);
      chk("rst_in_ready", 256'(in_ready), 256'(0));
      chk("rst_out_valid", 256'(out_valid), 256'(0));
      chk("rst_out_data", {v0_out, v1_out, v2_out, v3_out}, 256'(0));
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", 256'(in_ready), 256'(1));
      @(negedge clk);

      run_block(256'(0), 4'd2, 256'(0), "zero_r2");
      run_block({64'h1_0000_0000, 64'h2_0001, 64'h1_0000_0000, 64'h1_0000_0000}, 4'd1,
                {64'd1, 64'd0, 64'd0, 64'd0}, "vec_r1");
      run_block({64'hDEAD, 64'hBEEF, 64'h1234, 64'h5678}, 4'd0,
                {64'hDEAD, 64'hBEEF, 64'h1234, 64'h5678}, "pass_r0");

      for (int i = 0; i < 1000; i++) begin
         pre = rnd_state();
         r = $urandom_range(8, 1);
         post = fwd_n(pre, r);
         run_block(post, 4'(r), pre, "rand");
      end

      pre = rnd_state();
      run_block(fwd_n(pre, 8), 4'd15, pre, "clamp_r15");

      // Backpressure: result must hold while out_ready is low.
      pre = rnd_state();
      post = fwd_n(pre, 1);
      out_ready = 1'b0;
      exp_q.push_back(pre);
      {v0_in, v1_in, v2_in, v3_in} = post;
      in_rounds = 4'd1;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      k = 0;
      while (!out_valid && k < 60) begin
         @(negedge clk);
         k++;
      end
      hold = exp_q.pop_front();
      for (int i = 0; i < 10; i++) begin
         chk("bp_valid", 256'(out_valid), 256'(1));
         chk("bp_data", {v0_out, v1_out, v2_out, v3_out}, hold);
         chk("bp_in_ready", 256'(in_ready), 256'(0));
         in_valid = i[0];
         {v0_in, v1_in, v2_in, v3_in} = rnd_state();
         in_rounds = 4'd3;
         @(negedge clk);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_hs_valid", 256'(out_valid), 256'(0));
      chk("bp_hs_in_ready", 256'(in_ready), 256'(1));
      @(negedge clk);
      chk("bp_no_ghost", 256'(out_valid), 256'(0));

      // Reset in the middle of RUN.
      pre = rnd_state();
      {v0_in, v1_in, v2_in, v3_in} = fwd_n(pre, 2);
      in_rounds = 4'd2;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("mid_rst_valid", 256'(out_valid), 256'(0));
      chk("mid_rst_data", {v0_out, v1_out, v2_out, v3_out}, 256'(0));
      chk("mid_rst_in_ready", 256'(in_ready), 256'(1));
`ifdef SIP_INV_BLK_CNT_EN
      chk("blk_cnt_clr", 256'(blk_cnt), 256'(0));
`endif
      @(negedge clk);
      run_block(fwd_n(pre, 3), 4'd3, pre, "after_rst");
`ifdef SIP_INV_BLK_CNT_EN
      chk("blk_cnt_one", 256'(blk_cnt), 256'(1));
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/sip_inv_rounds.md
Name: sip_inv_rounds

Overview:
- Iterative inverse-SipRound engine: takes a 4x64-bit SipHash state and applies N inverse SipRounds, recovering the pre-round state.
- Used as the decode direction of the round datapath: bench oracle and round-trip checker beside the forward round pipeline, and key/state recovery in debug builds.
- One inverse half-round per cycle; valid/ready on both sides.

Parameters:
- MAX_ROUNDS, 8, upper limit on the runtime round count; sets counter width (clog2(2*MAX_ROUNDS+1)).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active high
- in_valid  in  1  input state and round count valid
- in_ready  out  1  engine idle and accepting
- in_rounds  in  4  inverse SipRounds to apply; values above MAX_ROUNDS are clamped to MAX_ROUNDS
- v0_in, v1_in, v2_in, v3_in  in  64 each  post-round state
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- v0_out, v1_out, v2_out, v3_out  out  64 each  recovered state

Behaviour:
- Interface decision: one clock (clk); reset is synchronous and active-high (rst).
- Reset: FSM to IDLE; in_ready=0 during the reset cycle and 1 after; out_valid=0; v*_out=0; counter=0.
- FSM states:
  - IDLE: in_ready=1. On in_valid, load the state registers, load cnt=2*R and go to RUN. If R=0, go straight to DONE.
  - RUN: each cycle apply one inverse half-round and decrement cnt; on reaching 0 go to DONE.
  - DONE: out_valid=1 with the registers held stable until out_ready; on out_valid&&out_ready go to IDLE.
- Latency: accept at cycle T gives out_valid at T+2R+1. R=0 gives T+1 with output = input.
- No back-to-back overlap: in_ready=0 in RUN and DONE. The next accept is possible the cycle after the output handshake.
- Half-round order per inverse round: inverse-B first, then inverse-A. Cnt parity selects which: odd = A, even (nonzero) = B.
- Inverse-B, inputs (b0..b3):
  - s=rotr(b2,32); v1=rotr(b1^s,17); v2=s-v1
  - v3=rotr(b3^b0,21); v0=b0-v3
- Inverse-A, inputs (a0..a3):
  - s=rotr(a0,32); v1=rotr(a1^s,13); v0=s-v1
  - v3=rotr(a3^a2,16); v2=a2-v3
- Arithmetic rules: rotr is a true 64-bit rotate, never a shift. All subtractions are mod 2^64.
- rst asserted in RUN or DONE: in-flight result is discarded, outputs return to reset values next cycle.
- out_ready held high in DONE: handshake completes the first DONE cycle.
- in_valid while busy: ignored; upstream must hold its data until in_ready.

Optional Feature:
- Macro SIP_INV_BLK_CNT_EN.
- Defined: adds output blk_cnt (32 bits), incremented on every output handshake, cleared by rst, wraps 0xFFFF_FFFF to 0.
- Not defined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package sip_pkg holds:
  - rotation constants SIP_ROT_V1_A=13, SIP_ROT_V3_A=16, SIP_ROT_V1_B=17, SIP_ROT_V3_B=21, SIP_ROT_HALF=32
  - typedef sip_state_t (struct of four 64-bit lanes)
  - rotl64/rotr64 functions
  - FSM enum
- Sub-module sip_inv_half_round: purely combinational, parameters ROT_V1, ROT_V3, SWAP (selects A vs B lane roles). Instantiated twice; the result is muxed by cnt parity.

Test Plan:
- Zero state, R=2 -> out (0,0,0,0) at T+5.
- In (0x1_0000_0000, 0x2_0001, 0x1_0000_0000, 0x1_0000_0000), R=1 -> out (1,0,0,0) exactly 3 cycles after accept.
- R=0, in (0xDEAD,0xBEEF,0x1234,0x5678) -> identical out at T+1.
- Round-trip: 1000 random states, R random 1..8, pre-processed by a reference forward SipRound model -> original state returned. Also check R=15 clamps to 8.
- Backpressure: out_ready=0 for 10 cycles in DONE -> out_valid and data stable, in_ready=0, in_valid pulses ignored; then one handshake -> in_ready=1 next cycle.
- Reset mid-RUN (cycle T+2 of R=2) -> next cycle out_valid=0, outputs 0, in_ready=1. With SIP_INV_BLK_CNT_EN: blk_cnt=0, then 1 after one completed block.
